controlador_contador: RTL and testbench

CONTROLADOR_CONTADOR -- requirements
Module: controlador_contador

---
 rtl/controlador_contador.sv | 201 ++++++++++++++++++++
 tb/tb_controlador_contador.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/controlador_contador.sv
// Start/stop/clear BCD up/down counter with a multiplexed 4-digit 7-segment display.
// Define CONTADOR_BLANK_EN to blank leading zeros on the non-units digits.
module controlador_contador #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up_down,
  output logic [15:0] count_bcd,
  output logic [6:0]  display,
  output logic [3:0]  digit_en,
  output logic        running,
  output logic        wrap
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] PRESC_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   presc_q, presc_d;
  logic [15:0]     count_q, count_d;
  logic            wrap_q, wrap_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [1:0]      idx_q, idx_d;
  logic            step;
  logic [3:0]      sel_digit;
  logic [6:0]      seg;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else if (v[i*4 +: 4] > 4'd9) begin
          r[i*4 +: 4] = 4'd9;
          borrow      = 1'b0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: clear beats stop beats start
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (stop)  state_d = PAUSE;
        PAUSE:   if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State outputs
  always_comb begin
    running = (state_q == RUN);
  end

  // A pending stop or clear suppresses both the step and the prescaler advance,
  // so a resume from PAUSE finishes the interrupted step period exactly.
  always_comb begin
    step    = (state_q == RUN) && !stop && !clear && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if ((state_q == IDLE) && start) begin
      presc_d = '0;
    end else if ((state_q == RUN) && !stop) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + TW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      if (up_down) begin
        count_d = bcd_inc(count_q);
        wrap_d  = (count_q == 16'h9999);
      end else begin
        count_d = bcd_dec(count_q);
        wrap_d  = (count_q == 16'h0000);
      end
    end
  end

  always_comb begin
    scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + SW'(1);
    idx_d  = (scan_q == SCAN_MAX) ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    count_bcd = count_q;
    wrap      = wrap_q;
    digit_en  = ~(4'b0001 << idx_q);
    sel_digit = count_q[{idx_q, 2'b00} +: 4];
    seg       = seg7(sel_digit);
  end

`ifdef CONTADOR_BLANK_EN
  logic blank;

  always_comb begin
    case (idx_q)
      2'd3:    blank = (count_q[15:12] == 4'd0);
      2'd2:    blank = (count_q[15:8]  == 8'd0);
      2'd1:    blank = (count_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    display = blank ? 7'b1111111 : seg;
  end
`else
  always_comb begin
    display = seg;
  end
`endif

endmodule

// File: tb/tb_controlador_contador.sv
// Directed bench for controlador_contador with TICK_DIV=4, SCAN_DIV=2.
module tb_controlador_contador;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, up_down;
  logic [15:0] count_bcd;
  logic [6:0]  display;
  logic [3:0]  digit_en;
  logic        running, wrap;

  controlador_contador #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up_down  (up_down),
    .count_bcd(count_bcd),
    .display  (display),
    .digit_en (digit_en),
    .running  (running),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        clear;
    logic        up;
    logic [15:0] count;
    logic        running;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic s, input logic p, input logic c, input logic u,
                     input logic [15:0] cnt, input logic run, input logic wr, input int rep = 1);
    for (int i = 0; i < rep; i++) vecs.push_back('{s, p, c, u, cnt, run, wr});
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_en[4];
    logic [6:0] exp_seg[4];
    int         t;

    exp_en[0] = 4'b1110; exp_en[1] = 4'b1101; exp_en[2] = 4'b1011; exp_en[3] = 4'b0111;
    exp_seg[0] = 7'b0010010;
    exp_seg[1] = 7'b1001100;
`ifdef CONTADOR_BLANK_EN
    exp_seg[2] = 7'b1111111;
    exp_seg[3] = 7'b1111111;
`else
    exp_seg[2] = 7'b0000001;
    exp_seg[3] = 7'b0000001;
`endif

    // start stop clear up | count running wrap
    add(1, 0, 0, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 1, 0, 3);
    add(0, 0, 0, 1, 16'h0001, 1, 0);
    add(0, 0, 0, 1, 16'h0001, 1, 0, 3);
    add(0, 0, 0, 1, 16'h0002, 1, 0);
    add(0, 0, 0, 1, 16'h0002, 1, 0, 2);   // prescaler reaches 2
    add(0, 1, 0, 1, 16'h0002, 0, 0);      // stop
    add(0, 0, 0, 1, 16'h0002, 0, 0, 10);
    add(1, 0, 0, 1, 16'h0002, 1, 0);      // resume
    add(0, 0, 0, 1, 16'h0002, 1, 0);
    add(0, 0, 0, 1, 16'h0003, 1, 0);      // step 2 cycles after resume
    add(0, 0, 0, 0, 16'h0003, 1, 0, 3);
    add(0, 0, 0, 0, 16'h0002, 1, 0);
    add(1, 1, 1, 0, 16'h0000, 0, 0);      // clear wins
    add(1, 0, 0, 0, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 3);
    add(0, 0, 0, 0, 16'h9999, 1, 1);      // down wrap
    add(0, 0, 0, 0, 16'h9999, 1, 0, 3);
    add(0, 0, 0, 0, 16'h9998, 1, 0);
    add(0, 0, 0, 1, 16'h9998, 1, 0, 3);
    add(0, 0, 0, 1, 16'h9999, 1, 0);
    add(0, 0, 0, 1, 16'h9999, 1, 0, 3);
    add(0, 0, 0, 1, 16'h0000, 1, 1);      // up wrap
    add(0, 0, 0, 1, 16'h0000, 1, 0);
    add(0, 0, 1, 1, 16'h0000, 0, 0);
    add(0, 1, 0, 1, 16'h0000, 0, 0);      // stop in IDLE ignored

    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; up_down = 1'b1;
    tick();
    chk("reset count", count_bcd, 16'h0000);
    chk("reset running", 16'(running), 16'd0);
    chk("reset wrap", 16'(wrap), 16'd0);
    chk("reset digit_en", 16'(digit_en), 16'(4'b1110));
    chk("reset display", 16'(display), 16'(7'b0000001));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop; clear = vecs[i].clear; up_down = vecs[i].up;
      tick();
      chk($sformatf("v%0d count", i), count_bcd, vecs[i].count);
      chk($sformatf("v%0d running", i), 16'(running), 16'(vecs[i].running));
      chk($sformatf("v%0d wrap", i), 16'(wrap), 16'(vecs[i].wrap));
    end
    stop = 1'b0;

    // Count up to 0042 and pause there
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; up_down = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      repeat (4) tick();
      chk($sformatf("up step %0d", k), count_bcd, to_bcd(k));
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("pause running", 16'(running), 16'd0);
    chk("pause count", count_bcd, 16'h0042);

    t = 0;
    while (digit_en !== 4'b0111 && t < 20) begin tick(); t++; end
    while (digit_en !== 4'b1110 && t < 20) begin tick(); t++; end
    chk("scan sync in budget", 16'(t < 20), 16'd1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("slot%0d.%0d digit_en", s, c), 16'(digit_en), 16'(exp_en[s]));
        chk($sformatf("slot%0d.%0d display", s, c), 16'(display), 16'(exp_seg[s]));
        tick();
      end
    end
    chk("scan count held", count_bcd, 16'h0042);

    // Resume to 0100, then one down step
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 43; k <= 100; k++) begin
      repeat (4) tick();
      chk($sformatf("up step %0d", k), count_bcd, to_bcd(k));
    end
    up_down = 1'b0;
    repeat (3) tick();
    chk("dir change no early step", count_bcd, 16'h0100);
    tick();
    chk("0100 down", count_bcd, 16'h0099);
    chk("0100 down wrap", 16'(wrap), 16'd0);

    // Asynchronous reset mid-RUN
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("async rst count", count_bcd, 16'h0000);
    chk("async rst running", 16'(running), 16'd0);
    chk("async rst digit_en", 16'(digit_en), 16'(4'b1110));
    chk("async rst display", 16'(display), 16'(7'b0000001));
    tick();
    chk("rst hold wrap", 16'(wrap), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("post rst idle", 16'(running), 16'd0);
      chk("post rst no wrap", 16'(wrap), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
